// File: rtl/button_mode_controller_pkg.sv
// Shared mode encodings and the mode-step helper for button_mode_controller.
`default_nettype none

package button_mode_controller_pkg;

  typedef enum logic [1:0] {
    MODE_ARITH   = 2'd0,
    MODE_LOGIC   = 2'd1,
    MODE_COMPARE = 2'd2,
    MODE_MAGIC   = 2'd3
  } mode_e;

  // Up/next steps forward, down/previous steps back; both or neither hold.
  function automatic mode_e step_mode(input mode_e cur, input logic [1:0] pulses);
    mode_e nxt;
    nxt = cur;
    case (pulses)
      2'b01:   nxt = mode_e'(cur + 2'd1);
      2'b10:   nxt = mode_e'(cur - 2'd1);
      default: nxt = cur;
    endcase
    return nxt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/button_mode_controller_conditioner.sv
// button_conditioner: synchroniser, debounce, press-edge pulse and auto-repeat for one active-low button.
`default_nettype none

module button_conditioner
  import button_mode_controller_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int REPEAT_DELAY    = 10000000,
  parameter int REPEAT_PERIOD   = 2500000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic button_n,
  output logic level,
  output logic press
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES > 2 ? DEBOUNCE_CYCLES : 2);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic            sync_1;
  logic            sync_2;
  logic [DB_W-1:0] db_cnt;
  logic            level_d;
  logic            level_flip;
  logic            repeat_fire;

  assign level_flip = (sync_2 != level) && (db_cnt == DB_LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_1  <= 1'b0;
      sync_2  <= 1'b0;
      db_cnt  <= '0;
      level   <= 1'b0;
      level_d <= 1'b0;
      press   <= 1'b0;
    end else begin
      sync_1  <= ~button_n;
      sync_2  <= sync_1;
      level_d <= level;
      press   <= (level & ~level_d) | repeat_fire;
      if (sync_2 == level) begin
        db_cnt <= '0;
      end else if (level_flip) begin
        db_cnt <= '0;
        level  <= ~level;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  if (REPEAT_DELAY != 0) begin : g_repeat
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX > 2 ? RPT_MAX : 2);
    localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

    logic [RPT_W-1:0] rpt_cnt;
    logic [RPT_W-1:0] elapsed;
    logic [RPT_W-1:0] target_last;
    logic             repeating;

    // Any pulse restarts the interval; a pending release suppresses the repeat.
    assign elapsed     = press ? '0 : rpt_cnt;
    assign target_last = repeating ? PERIOD_LAST : DELAY_LAST;
    assign repeat_fire = level & level_d & ~level_flip & (elapsed == target_last);

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        rpt_cnt   <= '0;
        repeating <= 1'b0;
      end else if (!level) begin
        rpt_cnt   <= '0;
        repeating <= 1'b0;
      end else if (repeat_fire) begin
        rpt_cnt   <= '0;
        repeating <= 1'b1;
      end else if (elapsed != target_last) begin
        rpt_cnt <= elapsed + 1'b1;
      end
    end
  end else begin : g_no_repeat
    assign repeat_fire = 1'b0;
  end

endmodule

`default_nettype wire

// File: rtl/button_mode_controller.sv
// button_mode_controller: two conditioned buttons stepping a registered 2-bit mode with change strobe.
`default_nettype none

module button_mode_controller
  import button_mode_controller_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int REPEAT_DELAY    = 10000000,
  parameter int REPEAT_PERIOD   = 2500000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] buttons,
  output logic [1:0] button_level,
  output logic [1:0] press,
  output logic [1:0] mode,
  output logic       mode_changed
);

  mode_e mode_q;

  for (genvar i = 0; i < 2; i++) begin : g_button
    button_conditioner #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_cond (
      .clock   (clock),
      .reset_n (reset_n),
      .button_n(buttons[i]),
      .level   (button_level[i]),
      .press   (press[i])
    );
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mode_q       <= MODE_ARITH;
      mode_changed <= 1'b0;
    end else begin
      mode_q       <= step_mode(mode_q, press);
      mode_changed <= (press == 2'b01) || (press == 2'b10);
    end
  end

  assign mode = mode_q;

endmodule

`default_nettype wire

// File: tb/tb_button_mode_controller.sv
// Randomized bench for button_mode_controller against a timing-rule reference model.
`default_nettype none

module tb_button_mode_controller;

  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RP = 8;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] buttons = 2'b11;
  logic [1:0] button_level;
  logic [1:0] press;
  logic [1:0] mode;
  logic       mode_changed;

  int vectors = 0;
  int miscompares = 0;

  button_mode_controller #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .buttons     (buttons),
    .button_level(button_level),
    .press       (press),
    .mode        (mode),
    .mode_changed(mode_changed)
  );

  always #5 clock = ~clock;

  // Reference model state: sample history, accepted levels, rise times, expectations.
  int       cyc;
  bit [1:0] ms1, ms2;
  bit [1:0] histq[$];
  bit [1:0] mlvl;
  int       rise[2];
  bit [1:0] exp_press;
  bit [1:0] exp_mode;
  bit       exp_mchg;

  task automatic check_value(input string tag, input logic [7:0] got, input logic [7:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, want);
    end
  endtask

  task automatic model_reset();
    cyc = 0;
    ms1 = '0;
    ms2 = '0;
    histq.delete();
    mlvl = '0;
    rise[0] = -1000;
    rise[1] = -1000;
    exp_press = '0;
    exp_mode = '0;
    exp_mchg = 1'b0;
  endtask

  task automatic model_edge(input bit [1:0] raw);
    bit [1:0] e;
    bit       all_differ;
    int       k;
    cyc++;
    // Mode reacts to the pulses of the previous cycle.
    exp_mchg = (exp_press == 2'b01) || (exp_press == 2'b10);
    if (exp_press == 2'b01) exp_mode = exp_mode + 2'd1;
    if (exp_press == 2'b10) exp_mode = exp_mode - 2'd1;
    // Accept a new level once the synchronised value disagreed for DB consecutive samples.
    histq.push_back(ms2);
    if (histq.size() > DB) void'(histq.pop_front());
    for (int i = 0; i < 2; i++) begin
      if (histq.size() == DB) begin
        all_differ = 1'b1;
        foreach (histq[j]) begin
          e = histq[j];
          if (e[i] == mlvl[i]) all_differ = 1'b0;
        end
        if (all_differ) begin
          mlvl[i] = ~mlvl[i];
          if (mlvl[i]) rise[i] = cyc;
        end
      end
    end
    ms2 = ms1;
    ms1 = ~raw;
    // Pulse one cycle after the rise, then at +RD and every RP after while held.
    for (int i = 0; i < 2; i++) begin
      k = cyc - rise[i] - 1;
      exp_press[i] = mlvl[i] && (k >= 0) && ((k == 0) || (k >= RD && ((k - RD) % RP) == 0));
    end
  endtask

  task automatic compare_outputs();
    check_value("button_level", {6'd0, button_level}, {6'd0, mlvl});
    check_value("press",        {6'd0, press},        {6'd0, exp_press});
    check_value("mode",         {6'd0, mode},         {6'd0, exp_mode});
    check_value("mode_changed", {7'd0, mode_changed}, {7'd0, exp_mchg});
  endtask

  task automatic step(input bit [1:0] raw);
    buttons = raw;
    @(posedge clock);
    if (reset_n) model_edge(raw);
    else         model_reset();
    @(negedge clock);
    compare_outputs();
  endtask

  task automatic hold(input bit [1:0] raw, input int n);
    for (int c = 0; c < n; c++) step(raw);
  endtask

  task automatic do_reset(input bit [1:0] raw, input int n);
    reset_n = 1'b0;
    buttons = raw;
    model_reset();
    #1;
    compare_outputs();
    hold(raw, n);
    reset_n = 1'b1;
  endtask

  initial begin
    int       rem[2];
    bit [1:0] cur;
    model_reset();
    @(negedge clock);

    // Both buttons held through reset.
    do_reset(2'b00, 4);
    hold(2'b00, 10);
    hold(2'b11, 12);
    // Clean press of up, then release.
    hold(2'b10, 10);
    hold(2'b11, 12);
    // Bouncing press.
    hold(2'b10, 3);
    hold(2'b11, 1);
    hold(2'b10, 10);
    hold(2'b11, 12);
    // Down once, then up four times.
    hold(2'b01, 10);
    hold(2'b11, 12);
    for (int p = 0; p < 4; p++) begin
      hold(2'b10, 10);
      hold(2'b11, 12);
    end
    // Auto-repeat.
    hold(2'b10, 60);
    hold(2'b11, 12);
    // Simultaneous press.
    hold(2'b00, 10);
    hold(2'b11, 12);
    // Reset in the middle of a hold.
    hold(2'b01, 30);
    do_reset(2'b01, 3);
    hold(2'b01, 40);
    hold(2'b11, 12);

    // Random runs: short runs exercise bounce, long runs exercise debounce and repeat.
    cur = 2'b11;
    rem[0] = 0;
    rem[1] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (rem[i] == 0) begin
          cur[i] = 1'($urandom_range(0, 1));
          rem[i] = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 5) : $urandom_range(6, 70);
        end
        rem[i]--;
      end
      step(cur);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
